// File: rtl/f_le_pkg.sv
// Shared types and helpers for the chunked floating-point less-or-equal responder.
// Holds the FSM/order encodings, operand classification record and result resolution.
package f_le_pkg;

  localparam int FP64_FLEN = 64;
  localparam int FP64_NE   = 11;
  localparam int FP64_NM   = 52;

  typedef enum logic {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    EQ = 2'd0,
    LT = 2'd1,
    GT = 2'd2
  } ord_e;

  typedef struct packed {
    logic nan;
    logic zero;
    logic sign;
  } cls_t;

  typedef struct packed {
    logic res;
    logic err;
  } le_rsp_t;

  // Number of CHUNK-wide slices needed to cover the FLEN-1 magnitude bits.
  function automatic int calc_nchunk(input int flen, input int chunk);
    return (flen - 1 + chunk - 1) / chunk;
  endfunction

  // Sign/zero/NaN rules applied on top of the unsigned magnitude order.
  function automatic le_rsp_t le_resolve(input cls_t ca, input cls_t cb, input ord_e ord);
    le_rsp_t r;
    r.res = 1'b0;
    r.err = 1'b0;
    if (ca.nan || cb.nan) begin
      r.err = 1'b1;
    end else if (ca.zero && cb.zero) begin
      r.res = 1'b1;
    end else if (ca.sign && !cb.sign) begin
      r.res = 1'b1;
    end else if (!ca.sign && cb.sign) begin
      r.res = 1'b0;
    end else if (!ca.sign) begin
      r.res = (ord != GT);
    end else begin
      r.res = (ord != LT);
    end
    return r;
  endfunction

endpackage

// File: rtl/f_le_classify.sv
// Combinational IEEE-754 operand classifier: sign, NaN and signed-zero detection.
module f_le_classify #(
  parameter int FLEN = 64,
  parameter int NE   = 11
) (
  input  logic [FLEN-1:0] op,
  output logic            sign,
  output logic            is_nan,
  output logic            is_zero
);

  logic [NE-1:0]        exp_f;
  logic [FLEN-NE-2:0]   man_f;

  assign sign    = op[FLEN-1];
  assign exp_f   = op[FLEN-2 -: NE];
  assign man_f   = op[FLEN-NE-2:0];
  // Infinity (all-ones exponent, zero mantissa) is deliberately not NaN.
  assign is_nan  = (&exp_f) && (|man_f);
  assign is_zero = ~|op[FLEN-2:0];

endmodule

// File: rtl/f_less_or_equal_seq.sv
// Multi-cycle a <= b comparator: magnitudes compared CHUNK bits per cycle, MSB first,
// fixed latency of NCHUNK cycles after accept, response registered on the last CMP edge.
module f_less_or_equal_seq
  import f_le_pkg::*;
#(
  parameter int FLEN  = 64,
  parameter int NE    = 11,
  parameter int CHUNK = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            f_le_valid,
  output logic            f_le_ready,
  input  logic [FLEN-1:0] f_le_a,
  input  logic [FLEN-1:0] f_le_b,
  output logic            f_le_res_valid,
  output logic            f_le_res,
  output logic            f_le_err
);

  localparam int NCHUNK = calc_nchunk(FLEN, CHUNK);
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int MAGW   = NCHUNK * CHUNK;

  state_e              state;
  ord_e                ord_q;
  ord_e                ord_nxt;
  logic [IDXW-1:0]     idx;
  logic [FLEN-2:0]     a_q;
  logic [FLEN-2:0]     b_q;
  cls_t                cls_a;
  cls_t                cls_b;
  cls_t                cls_a_q;
  cls_t                cls_b_q;
  le_rsp_t             rsp;

  logic [NCHUNK-1:0][CHUNK-1:0] mag_a;
  logic [NCHUNK-1:0][CHUNK-1:0] mag_b;
  logic [CHUNK-1:0]             chunk_a;
  logic [CHUNK-1:0]             chunk_b;

  f_le_classify #(.FLEN(FLEN), .NE(NE)) u_cls_a (
    .op      (f_le_a),
    .sign    (cls_a.sign),
    .is_nan  (cls_a.nan),
    .is_zero (cls_a.zero)
  );

  f_le_classify #(.FLEN(FLEN), .NE(NE)) u_cls_b (
    .op      (f_le_b),
    .sign    (cls_b.sign),
    .is_nan  (cls_b.nan),
    .is_zero (cls_b.zero)
  );

  assign mag_a   = MAGW'(a_q);
  assign mag_b   = MAGW'(b_q);
  assign chunk_a = mag_a[idx];
  assign chunk_b = mag_b[idx];

  // First differing chunk (highest) decides; later chunks cannot override.
  always_comb begin
    ord_nxt = ord_q;
    if (ord_q == EQ && chunk_a != chunk_b) begin
      ord_nxt = (chunk_a < chunk_b) ? LT : GT;
    end
  end

  // Resolution uses ord_nxt so the last chunk's verdict lands on the same edge.
  assign rsp        = le_resolve(cls_a_q, cls_b_q, ord_nxt);
  assign f_le_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ord_q          <= EQ;
      idx            <= '0;
      a_q            <= '0;
      b_q            <= '0;
      cls_a_q        <= '0;
      cls_b_q        <= '0;
      f_le_res_valid <= 1'b0;
      f_le_res       <= 1'b0;
      f_le_err       <= 1'b0;
    end else begin
      f_le_res_valid <= 1'b0;
      if (state == IDLE) begin
        if (f_le_valid) begin
          a_q     <= f_le_a[FLEN-2:0];
          b_q     <= f_le_b[FLEN-2:0];
          cls_a_q <= cls_a;
          cls_b_q <= cls_b;
          ord_q   <= EQ;
          idx     <= IDXW'(NCHUNK - 1);
          state   <= CMP;
        end
      end else begin
        ord_q <= ord_nxt;
        if (idx == '0) begin
          f_le_res       <= rsp.res;
          f_le_err       <= rsp.err;
          f_le_res_valid <= 1'b1;
          state          <= IDLE;
        end else begin
          idx <= idx - 1'b1;
        end
      end
    end
  end

endmodule
